// File: rtl/tracker_link_sequencer.sv
// tracker_link_sequencer: parses SYNC,X,Y,CHK packets from the UART byte
// stream, applies accepted goals to the servo targets once per PWM period,
// and falls back to centre when valid packets stop arriving.
// Optional feature macro: SEQ_SLEW_LIMIT_EN (per-period slew limit on targets;
// when undefined the targets jump straight to the effective goal).
module tracker_link_sequencer #(
  parameter logic [7:0]  SYNC_BYTE        = 8'hA5,
  parameter logic [7:0]  CENTER           = 8'd128,
  parameter int unsigned MAX_STEP         = 8,
  parameter int unsigned TIMEOUT_FRAMES   = 50,
  parameter int unsigned BYTE_TIMEOUT_CYC = 52083
) (
  input  logic       clk50mhz,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       pwm_frame,
  output logic [7:0] target_x,
  output logic [7:0] target_y,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       link_lost,
  output logic [7:0] err_count
);

  localparam int unsigned TMR_W = $clog2(BYTE_TIMEOUT_CYC + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(BYTE_TIMEOUT_CYC);
  localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT_FRAMES);

  // Reject parameter values the datapath cannot represent.
  if (MAX_STEP < 1 || MAX_STEP > 255 || TIMEOUT_FRAMES < 1) begin : g_bad_param
    $error("tracker_link_sequencer: MAX_STEP must be 1..255 and TIMEOUT_FRAMES >= 1");
  end

  typedef enum logic [1:0] {S_SYNC, S_X, S_Y, S_CHK} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] byte_tmr;
  logic [WD_W-1:0]  wd_cnt;
  logic [7:0]       x_reg;
  logic [7:0]       y_reg;
  logic [7:0]       goal_x;
  logic [7:0]       goal_y;
  logic             ok_c;
  logic             err_c;
  logic             lat_x_c;
  logic             lat_y_c;
  logic             tmo_c;
  logic [7:0]       eff_x_c;
  logic [7:0]       eff_y_c;

  // Inter-byte timeout: only meaningful mid-packet and when no byte arrives.
  assign tmo_c = (state != S_SYNC) && !rx_valid && (byte_tmr == TMR_LIMIT);

  // Parser state register.
  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) state <= S_SYNC;
    else     state <= state_nxt;
  end

  // Parser next-state and per-byte actions.
  always_comb begin
    state_nxt = state;
    ok_c      = 1'b0;
    err_c     = 1'b0;
    lat_x_c   = 1'b0;
    lat_y_c   = 1'b0;
    case (state)
      S_SYNC: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_nxt = S_X;
      end
      S_X: begin
        if (rx_valid) begin
          lat_x_c   = 1'b1;
          state_nxt = S_Y;
        end else if (tmo_c) begin
          err_c     = 1'b1;
          state_nxt = S_SYNC;
        end
      end
      S_Y: begin
        if (rx_valid) begin
          lat_y_c   = 1'b1;
          state_nxt = S_CHK;
        end else if (tmo_c) begin
          err_c     = 1'b1;
          state_nxt = S_SYNC;
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          if (rx_data == (x_reg ^ y_reg)) ok_c = 1'b1;
          else                            err_c = 1'b1;
          state_nxt = S_SYNC;
        end else if (tmo_c) begin
          err_c     = 1'b1;
          state_nxt = S_SYNC;
        end
      end
      default: state_nxt = S_SYNC;
    endcase
  end

  // Inter-byte timer: cleared by every byte, idle while hunting for sync.
  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) begin
      byte_tmr <= '0;
    end else if (rx_valid || (state == S_SYNC)) begin
      byte_tmr <= '0;
    end else if (byte_tmr != TMR_LIMIT) begin
      byte_tmr <= byte_tmr + TMR_W'(1);
    end
  end

  // Payload capture and goal update on an accepted packet.
  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) begin
      x_reg  <= '0;
      y_reg  <= '0;
      goal_x <= CENTER;
      goal_y <= CENTER;
    end else begin
      if (lat_x_c) x_reg <= rx_data;
      if (lat_y_c) y_reg <= rx_data;
      if (ok_c) begin
        goal_x <= x_reg;
        goal_y <= y_reg;
      end
    end
  end

  // Status pulses and saturating error counter.
  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      frame_ok  <= ok_c;
      frame_err <= err_c;
      if (err_c && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  // Link watchdog: counts PWM periods since the last accepted packet.
  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      link_lost <= 1'b1;
    end else if (ok_c) begin
      wd_cnt    <= '0;
      link_lost <= 1'b0;
    end else if (pwm_frame && (wd_cnt != WD_LIMIT)) begin
      wd_cnt <= wd_cnt + WD_W'(1);
      if ((wd_cnt + WD_W'(1)) == WD_LIMIT) link_lost <= 1'b1;
    end
  end

  assign eff_x_c = link_lost ? CENTER : goal_x;
  assign eff_y_c = link_lost ? CENTER : goal_y;

`ifdef SEQ_SLEW_LIMIT_EN
  localparam logic [8:0] STEP_LIM = 9'(MAX_STEP);

  // Move cur toward goal by at most STEP_LIM; never overshoots, so no wrap.
  function automatic logic [7:0] slew_toward(input logic [7:0] cur, input logic [7:0] goal);
    logic [8:0] diff;
    logic [8:0] mag;
    logic [7:0] res;
    diff = {1'b0, goal} - {1'b0, cur};
    mag  = diff[8] ? (9'd0 - diff) : diff;
    if (mag <= STEP_LIM) res = goal;
    else if (diff[8])    res = cur - STEP_LIM[7:0];
    else                 res = cur + STEP_LIM[7:0];
    return res;
  endfunction

  // Targets advance one slew step per PWM period.
  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) begin
      target_x <= CENTER;
      target_y <= CENTER;
    end else if (pwm_frame) begin
      target_x <= slew_toward(target_x, eff_x_c);
      target_y <= slew_toward(target_y, eff_y_c);
    end
  end
`else
  // Targets jump to the effective goal once per PWM period.
  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) begin
      target_x <= CENTER;
      target_y <= CENTER;
    end else if (pwm_frame) begin
      target_x <= eff_x_c;
      target_y <= eff_y_c;
    end
  end
`endif

endmodule

// File: tb/tb_tracker_link_sequencer.sv
// Scoreboard bench for tracker_link_sequencer: stimulus tasks push expected
// frame events and target updates; a negedge monitor pops and compares.
module tb_tracker_link_sequencer;

  localparam int unsigned TB_STEP = 8;
  localparam int unsigned TB_TMO  = 50;

  logic       clk50mhz = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       pwm_frame = 1'b0;
  logic [7:0] target_x;
  logic [7:0] target_y;
  logic       frame_ok;
  logic       frame_err;
  logic       link_lost;
  logic [7:0] err_count;

  tracker_link_sequencer dut (
    .clk50mhz  (clk50mhz),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .pwm_frame (pwm_frame),
    .target_x  (target_x),
    .target_y  (target_y),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .link_lost (link_lost),
    .err_count (err_count)
  );

  always #10 clk50mhz = ~clk50mhz;

  typedef struct {
    bit         ok;
    logic [7:0] err;
    logic       lost;
  } ev_t;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] ty;
    logic       lost;
  } tg_t;

  ev_t ev_q[$];
  tg_t tg_q[$];
  ev_t ev_cur;
  tg_t tg_cur;
  int  n_vec = 0;
  int  n_bad = 0;

  // Reference model state
  logic [7:0] m_gx, m_gy, m_tx, m_ty, m_err;
  logic       m_lost;
  int         m_wd;
  logic       pwm_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_step(input logic [7:0] t, input logic [7:0] g);
`ifdef SEQ_SLEW_LIMIT_EN
    if (g > t) return ((g - t) > TB_STEP) ? t + 8'(TB_STEP) : g;
    if (t > g) return ((t - g) > TB_STEP) ? t - 8'(TB_STEP) : g;
    return g;
`else
    return g;
`endif
  endfunction

  task automatic model_reset();
    m_gx = 8'd128; m_gy = 8'd128;
    m_tx = 8'd128; m_ty = 8'd128;
    m_err = 8'd0;  m_lost = 1'b1; m_wd = 0;
    ev_q.delete();
    tg_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk50mhz);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk50mhz);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic expect_chk(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c);
    ev_t e;
    if (c == (x ^ y)) begin
      m_gx = x; m_gy = y; m_wd = 0; m_lost = 1'b0;
      e.ok = 1'b1;
    end else begin
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      e.ok = 1'b0;
    end
    e.err  = m_err;
    e.lost = m_lost;
    ev_q.push_back(e);
  endtask

  task automatic send_pkt(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(x);
    send_byte(y);
    expect_chk(x, y, c);
    send_byte(c);
    idle(2);
  endtask

  task automatic pwm_pulse();
    tg_t t;
    m_tx = m_step(m_tx, m_lost ? 8'd128 : m_gx);
    m_ty = m_step(m_ty, m_lost ? 8'd128 : m_gy);
    if (m_wd != TB_TMO) begin
      m_wd++;
      if (m_wd == TB_TMO) m_lost = 1'b1;
    end
    t.tx = m_tx; t.ty = m_ty; t.lost = m_lost;
    tg_q.push_back(t);
    pwm_frame = 1'b1;
    @(posedge clk50mhz);
    #1;
    pwm_frame = 1'b0;
    idle(2);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_target_x"}, target_x, 8'd128);
    check({tag, "_target_y"}, target_y, 8'd128);
    check({tag, "_frame_ok"}, frame_ok, 1'b0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_link_lost"}, link_lost, 1'b1);
    check({tag, "_err_count"}, err_count, 8'd0);
  endtask

  // Delayed copy of pwm_frame marks the cycle a target update is visible.
  always @(posedge clk50mhz) pwm_seen <= pwm_frame;

  // Monitor: compare every frame event and target update against the queues.
  always @(negedge clk50mhz) begin
    if (!rst) begin
      if (frame_ok || frame_err) begin
        if (ev_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_frame_event: ok=%0d err=%0d, expected no event", frame_ok, frame_err);
        end else begin
          ev_cur = ev_q.pop_front();
          check("frame_ok", frame_ok, ev_cur.ok);
          check("frame_err", frame_err, !ev_cur.ok);
          check("err_count", err_count, ev_cur.err);
          check("link_lost_at_frame", link_lost, ev_cur.lost);
        end
      end
      if (pwm_seen) begin
        if (tg_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_target_update: x=%0d y=%0d, expected none", target_x, target_y);
        end else begin
          tg_cur = tg_q.pop_front();
          check("target_x", target_x, tg_cur.tx);
          check("target_y", target_y, tg_cur.ty);
          check("link_lost_at_pwm", link_lost, tg_cur.lost);
        end
      end
    end
  end

  initial begin
    int waited;
    model_reset();
    repeat (3) @(posedge clk50mhz);
    #1;
    check_reset("reset");
    rst = 1'b0;
    idle(1);

    // Goal 64/192 and 13 periods of tracking
    send_pkt(8'h40, 8'hC0, 8'h80);
    repeat (13) pwm_pulse();

    // Bad checksum: goal and targets stay put
    send_pkt(8'h10, 8'h20, 8'h31);
    repeat (2) pwm_pulse();

    // Leading junk, sync value as payload
    send_byte(8'h00);
    send_pkt(8'hA5, 8'h00, 8'hA5);
    repeat (3) pwm_pulse();

    // Inter-byte timeout, then a clean packet
    send_byte(8'hA5);
    send_byte(8'h10);
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
    ev_cur.ok = 1'b0; ev_cur.err = m_err; ev_cur.lost = m_lost;
    ev_q.push_back(ev_cur);
    idle(52100);
    send_pkt(8'h01, 8'h02, 8'h03);

    // Goal 200/200, then link loss returns both axes to centre
    send_pkt(8'hC8, 8'hC8, 8'h00);
    repeat (50) pwm_pulse();
    repeat (12) pwm_pulse();

    // Full-range goal
    send_pkt(8'hFF, 8'h00, 8'hFF);
    pwm_pulse();

    // Error counter saturation
    repeat (300) send_pkt(8'h00, 8'h00, 8'h01);

    // Reset mid-packet: the partial packet must be discarded
    send_byte(8'hA5);
    send_byte(8'h10);
    rst = 1'b1;
    #2;
    model_reset();
    check_reset("midreset");
    idle(2);
    rst = 1'b0;
    idle(1);
    send_byte(8'h20);
    send_byte(8'h30);
    idle(3);
    pwm_pulse();

    waited = 0;
    while ((ev_q.size() + tg_q.size()) != 0 && waited < 20) begin
      idle(1);
      waited++;
    end
    check("queue_drain", 32'(ev_q.size() + tg_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
